// File: rtl/control_signals.sv
// CCD readout timing generator: divides clk into pixel periods and drives the shift clocks,
// the per-pixel reset gate and the once-per-line transfer pulse from registered decode.
module control_signals #(
  parameter int unsigned PIXELS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] max_val,
  output logic       phi_p,
  output logic       phi_l1,
  output logic       phi_l2,
  output logic       phi_r
);

  localparam int unsigned PixW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [PixW-1:0] PixLast = PixW'(PIXELS - 1);

  logic [3:0]      count_q, count_d;
  logic [3:0]      period_q, period_d;
  logic [PixW-1:0] pix_q, pix_d;
  logic [3:0]      max_eff;
  logic [4:0]      half;
  logic            wrap;

  logic phi_p_q, phi_p_d;
  logic phi_l1_q, phi_l1_d;
  logic phi_l2_q, phi_l2_d;
  logic phi_r_q, phi_r_d;

  // Period counter and pixel index; max_val is only looked at on the wrap edge.
  always_comb begin
    max_eff  = (max_val < 4'd3) ? 4'd3 : max_val;
    wrap     = (count_q >= period_q);
    count_d  = count_q + 4'd1;
    period_d = period_q;
    pix_d    = pix_q;
    if (wrap) begin
      count_d  = 4'd0;
      period_d = max_eff;
      pix_d    = (pix_q == PixLast) ? '0 : pix_q + 1'b1;
    end
  end

  // Decode of the current state; registered below so the pins are glitch-free.
  always_comb begin
    half     = ({1'b0, period_q} + 5'd1) >> 1;
    phi_r_d  = (count_q == 4'd0);
    phi_p_d  = 1'b0;
    phi_l1_d = 1'b0;
    phi_l2_d = 1'b0;
    if (pix_q == '0) begin
      phi_p_d  = (count_q != 4'd0) && (count_q < period_q);
      phi_l1_d = 1'b1;
    end else begin
      phi_l1_d = ({1'b0, count_q} < half);
      phi_l2_d = ~phi_l1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 4'd0;
      period_q <= 4'd15;
      pix_q    <= '0;
      phi_p_q  <= 1'b0;
      phi_l1_q <= 1'b0;
      phi_l2_q <= 1'b0;
      phi_r_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
      pix_q    <= pix_d;
      phi_p_q  <= phi_p_d;
      phi_l1_q <= phi_l1_d;
      phi_l2_q <= phi_l2_d;
      phi_r_q  <= phi_r_d;
    end
  end

  assign phi_p  = phi_p_q;
  assign phi_l1 = phi_l1_q;
  assign phi_l2 = phi_l2_q;
  assign phi_r  = phi_r_q;

endmodule

// File: tb/tb_control_signals.sv
// Bench for control_signals: a waveform-queue reference model checks every cycle, plus a table
// of per-max_val line measurements and hand sequences for reset and mid-period changes.
module tb_control_signals;

  localparam int unsigned PIXELS = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] max_val = 4'd15;
  logic       phi_p, phi_l1, phi_l2, phi_r;

  int checks = 0;
  int errors = 0;

  // Expected pin values {phi_p, phi_l1, phi_l2, phi_r}, one entry per clock edge.
  logic [3:0] exp_q[$];
  int         model_pix;
  logic [3:0] cur;

  typedef struct {
    logic [3:0] mv;
    int         line;
    int         pw;
    int         l1tot;
  } vec_t;

  control_signals #(.PIXELS(PIXELS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .max_val(max_val),
    .phi_p  (phi_p),
    .phi_l1 (phi_l1),
    .phi_l2 (phi_l2),
    .phi_r  (phi_r)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted, got no finish, required finish");
    $fatal(1);
  end

  function automatic int eff(input logic [3:0] m);
    return (m < 4'd3) ? 3 : int'(m);
  endfunction

  // Whole-pixel waveform from the timing rules: length P+1, reset gate at the start.
  task automatic build_pixel(input int p_val, input int pix);
    for (int k = 0; k <= p_val; k++) begin
      logic pp, l1, l2, r;
      r = (k == 0);
      if (pix == 0) begin
        pp = (k >= 1) && (k <= p_val - 1);
        l1 = 1'b1;
        l2 = 1'b0;
      end else begin
        pp = 1'b0;
        l1 = (k < (p_val + 1) / 2);
        l2 = !l1;
      end
      exp_q.push_back({pp, l1, l2, r});
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_pix = 0;
    build_pixel(15, 0);
  endtask

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, expv);
    end
  endtask

  task automatic step();
    logic [3:0] e;
    @(posedge clk);
    if (rst_n) begin
      e = exp_q.pop_front();
      if (exp_q.size() == 0) begin
        model_pix = (model_pix + 1) % PIXELS;
        build_pixel(eff(max_val), model_pix);
      end
    end else begin
      e = 4'd0;
    end
    #1;
    cur = {phi_p, phi_l1, phi_l2, phi_r};
    chk("outputs_vs_model", int'(cur), int'(e));
    chk("invariants", int'(!(phi_l1 && phi_l2) && !(phi_p && phi_r) && (!phi_p || phi_l1)), 1);
  endtask

  // Window from the 2nd to the 3rd phi_p rise after the change is a full line at the new period.
  task automatic measure(output int line, output int pw, output int l1);
    int   rises;
    logic prev;
    rises = 0;
    line  = 0;
    pw    = 0;
    l1    = 0;
    prev  = cur[3];
    for (int i = 0; i < 1000 && rises < 3; i++) begin
      step();
      if (cur[3] && !prev) rises++;
      if (rises == 2) begin
        line++;
        if (cur[3]) pw++;
        if (cur[2]) l1++;
      end
      prev = cur[3];
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   rq[$];
    int   n, line, pw, l1;

    vecs[0] = '{mv: 4'd15, line: 128, pw: 14, l1tot: 72};
    vecs[1] = '{mv: 4'd9,  line: 80,  pw: 8,  l1tot: 45};
    vecs[2] = '{mv: 4'd3,  line: 32,  pw: 2,  l1tot: 18};
    vecs[3] = '{mv: 4'd1,  line: 32,  pw: 2,  l1tot: 18};
    vecs[4] = '{mv: 4'd4,  line: 40,  pw: 3,  l1tot: 19};
    vecs[5] = '{mv: 4'd0,  line: 32,  pw: 2,  l1tot: 18};

    model_reset();
    repeat (3) step();

    // Release: first edge decodes c = 0, pix 0.
    rst_n = 1'b1;
    step();
    chk("first_edge_phi_r", phi_r, 1);
    chk("first_edge_phi_l1", phi_l1, 1);
    chk("first_edge_phi_l2", phi_l2, 0);
    chk("first_edge_phi_p", phi_p, 0);

    // 15 -> 3 mid-period: first period stays 16 cycles, then 4-cycle periods.
    repeat (4) step();
    max_val = 4'd3;
    n = 5;
    rq.delete();
    for (int i = 0; i < 30; i++) begin
      step();
      n++;
      if (phi_r) rq.push_back(n);
    end
    chk("midchange_r_count", int'(rq.size() >= 3), 1);
    if (rq.size() >= 3) begin
      chk("midchange_r_1", rq[0], 17);
      chk("midchange_r_2", rq[1], 21);
      chk("midchange_r_3", rq[2], 25);
    end

    foreach (vecs[i]) begin
      max_val = vecs[i].mv;
      measure(line, pw, l1);
      chk($sformatf("line_len_mv%0d", vecs[i].mv), line, vecs[i].line);
      chk($sformatf("phi_p_width_mv%0d", vecs[i].mv), pw, vecs[i].pw);
      chk($sformatf("phi_l1_total_mv%0d", vecs[i].mv), l1, vecs[i].l1tot);
    end

    // Reset asserted at pix 5, c = 7, then restart with a 16-cycle first period.
    max_val = 4'd15;
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
    repeat (87) step();
    chk("pre_reset_phi_l1", phi_l1, 1);
    #2;
    rst_n = 1'b0;
    max_val = 4'd3;
    #1;
    chk("async_reset_outputs", int'({phi_p, phi_l1, phi_l2, phi_r}), 0);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    n = 0;
    rq.delete();
    for (int i = 0; i < 24; i++) begin
      step();
      n++;
      if (phi_r) rq.push_back(n);
    end
    chk("restart_r_count", int'(rq.size() >= 3), 1);
    if (rq.size() >= 3) begin
      chk("restart_r_1", rq[0], 1);
      chk("restart_r_2", rq[1], 17);
      chk("restart_r_3", rq[2], 21);
    end

    // Random max_val changes and occasional resets, checked against the model every cycle.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) max_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
